// File: rtl/uart_sort_pkg.sv
// Shared types and constants for the UART byte-sorting controller.
package uart_sort_pkg;

    localparam int DEFAULT_NUM_BYTES = 8;
    localparam int DEFAULT_DATA_W    = 8;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SORT      = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } sort_state_t;

    // Number of compare cycles a full bubble sort of n entries takes.
    function automatic int sort_cycles(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare/swap cell for the bubble sort.
// Macro UART_SORT_DESCEND_EN selects descending order; ascending by default.
// Equal operands never swap, which keeps the sort stable.
module sort_cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              swap
);

    // Decide whether the pair is out of order and produce the ordered pair.
    always_comb begin
`ifdef UART_SORT_DESCEND_EN
        swap = (a < b);
`else
        swap = (a > b);
`endif
        out_a = swap ? b : a;
        out_b = swap ? a : b;
    end

endmodule

// File: rtl/uart_sort_ctrl.sv
// Collects a frame of received bytes, bubble-sorts it in place with one
// compare per cycle, then hands the sorted bytes to the transmitter.
// Macro UART_SORT_DESCEND_EN (in sort_cmp_swap) flips the sort order;
// timing is identical in both builds.
module uart_sort_ctrl
    import uart_sort_pkg::*;
#(
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              i_CLOCK,
    input  logic              i_RESET_N,
    input  logic              i_Rx_DV,
    input  logic [DATA_W-1:0] i_Rx_Byte,
    output logic              o_Tx_DV,
    output logic [DATA_W-1:0] o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Rx_Overrun
);

    localparam int IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int SORT_CYCLES = sort_cycles(NUM_BYTES);
    localparam int CNT_W       = $clog2(SORT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(NUM_BYTES - 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SORT_CYCLES - 1);

    sort_state_t state_q;
    sort_state_t state_d;

    logic [DATA_W-1:0] buffer [NUM_BYTES];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] j_idx;
    logic [IDX_W-1:0] j_nxt;
    logic [IDX_W-1:0] j_last;
    logic [CNT_W-1:0] sort_cnt;

    logic              tx_dv;
    logic [DATA_W-1:0] tx_byte;
    logic              frame_done;
    logic              rx_overrun;

    logic rx_accept;
    logic rx_drop;
    logic sort_done;
    logic tx_launch;
    logic tx_next;
    logic frame_end;

    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_swap;

    assign j_nxt = j_idx + IDX_W'(1);

    sort_cmp_swap #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a     (buffer[j_idx]),
        .b     (buffer[j_nxt]),
        .out_a (cmp_a),
        .out_b (cmp_b),
        .swap  (cmp_swap)
    );

    // State register; reset abandons any frame in progress.
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the per-cycle control strobes it implies.
    always_comb begin
        state_d   = state_q;
        rx_accept = 1'b0;
        rx_drop   = 1'b0;
        sort_done = 1'b0;
        tx_launch = 1'b0;
        tx_next   = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            COLLECT: begin
                if (i_Rx_DV) begin
                    rx_accept = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        state_d = SORT;
                    end
                end
            end
            SORT: begin
                if (sort_cnt == LAST_CNT) begin
                    sort_done = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!i_Tx_Active) begin
                    tx_launch = 1'b1;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (rd_idx == LAST_IDX) begin
                        frame_end = 1'b1;
                        state_d   = COLLECT;
                    end else begin
                        tx_next = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (i_Rx_DV && (state_q != COLLECT)) begin
            rx_drop = 1'b1;
        end
    end

    // Indices, sort sequencing and registered output pulses.
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            j_idx      <= '0;
            j_last     <= LAST_J;
            sort_cnt   <= '0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
            frame_done <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            tx_dv      <= tx_launch;
            frame_done <= frame_end;
            rx_overrun <= rx_drop;

            if (rx_accept) begin
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
            end

            if (state_q == SORT) begin
                sort_cnt <= sort_cnt + CNT_W'(1);
                if (j_idx == j_last) begin
                    j_idx  <= '0;
                    j_last <= j_last - IDX_W'(1);
                end else begin
                    j_idx <= j_nxt;
                end
            end else begin
                sort_cnt <= '0;
                j_idx    <= '0;
                j_last   <= LAST_J;
            end

            if (tx_launch) begin
                tx_byte <= buffer[rd_idx];
            end

            if (sort_done || frame_end) begin
                rd_idx <= '0;
            end else if (tx_next) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
        end
    end

    // Frame storage: filled while collecting, reordered in place while sorting.
    always_ff @(posedge i_CLOCK) begin
        if (rx_accept) begin
            buffer[wr_idx] <= i_Rx_Byte;
        end
        if ((state_q == SORT) && cmp_swap) begin
            buffer[j_idx] <= cmp_a;
            buffer[j_nxt] <= cmp_b;
        end
    end

    assign o_Tx_DV      = tx_dv;
    assign o_Tx_Byte    = tx_byte;
    assign o_Busy       = (state_q != COLLECT);
    assign o_Frame_Done = frame_done;
    assign o_Rx_Overrun = rx_overrun;

endmodule

// File: tb/tb_uart_sort_ctrl.sv
// Self-checking bench for uart_sort_ctrl (NUM_BYTES=8, DATA_W=8).
// Expected order follows UART_SORT_DESCEND_EN when defined for the build.
module tb_uart_sort_ctrl;

    localparam int NB = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_dv;
    logic [DW-1:0] rx_byte;
    logic          tx_dv;
    logic [DW-1:0] tx_byte;
    logic          tx_active;
    logic          tx_done;
    logic          busy;
    logic          frame_done;
    logic          rx_overrun;

    logic emu_active;
    logic emu_done;
    logic hold_active;
    logic spurious_done;

    assign tx_active = emu_active | hold_active;
    assign tx_done   = emu_done | spurious_done;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int frame_done_cnt = 0;
    int overrun_cnt = 0;
    int tx_len = 5;
    int last_rx_cyc = 0;

    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    logic [7:0] expected [$];
    logic [7:0] frame_in [NB];

    uart_sort_ctrl #(
        .NUM_BYTES (NB),
        .DATA_W    (DW)
    ) dut (
        .i_CLOCK      (clk),
        .i_RESET_N    (rst_n),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_Busy       (busy),
        .o_Frame_Done (frame_done),
        .o_Rx_Overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to measure latencies.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transmitter stand-in: busy for tx_len cycles after each start, then a done pulse.
    initial begin
        emu_active = 1'b0;
        emu_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_dv === 1'b1) begin
                @(negedge clk);
                emu_active = 1'b1;
                repeat (tx_len) @(negedge clk);
                emu_active = 1'b0;
                emu_done   = 1'b1;
                @(negedge clk);
                emu_done = 1'b0;
            end
        end
    end

    // Output monitor: logs transmitted bytes, counts pulses, checks pulse/hold rules.
    initial begin
        logic       prev_dv;
        logic       in_flight;
        logic [7:0] held;
        prev_dv   = 1'b0;
        in_flight = 1'b0;
        held      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                prev_dv   = 1'b0;
                in_flight = 1'b0;
            end else begin
                if (in_flight) begin
                    compared++;
                    if (tx_byte !== held) begin
                        mismatched++;
                        $display("[TB] FAIL tx_byte_hold: got %h, want %h", tx_byte, held);
                    end
                    if (tx_done === 1'b1) in_flight = 1'b0;
                end
                if (tx_dv === 1'b1) begin
                    compared++;
                    if (prev_dv) begin
                        mismatched++;
                        $display("[TB] FAIL tx_dv_consecutive: got 1 on two cycles, want single pulse");
                    end
                    tx_log.push_back(tx_byte);
                    tx_cyc.push_back(cyc);
                    held      = tx_byte;
                    in_flight = 1'b1;
                end
                if (frame_done === 1'b1) frame_done_cnt++;
                if (rx_overrun === 1'b1) overrun_cnt++;
                prev_dv = tx_dv;
            end
        end
    end

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: emit each value in order of magnitude, as many times as it was received.
    task automatic build_expected();
        expected.delete();
`ifdef UART_SORT_DESCEND_EN
        for (int v = 255; v >= 0; v--) begin
`else
        for (int v = 0; v < 256; v++) begin
`endif
            for (int k = 0; k < NB; k++) begin
                if (frame_in[k] == 8'(v)) expected.push_back(frame_in[k]);
            end
        end
    endtask

    task automatic random_frame(input bit dup_heavy);
        for (int k = 0; k < NB; k++) begin
            if (dup_heavy) frame_in[k] = 8'($urandom_range(0, 3) * 85);
            else           frame_in[k] = 8'($urandom_range(0, 255));
        end
    endtask

    // Feed frame_in as one-cycle pulses with random gaps; returns at the negedge after the last byte.
    task automatic send_frame();
        int gap;
        for (int k = 0; k < NB; k++) begin
            rx_dv   = 1'b1;
            rx_byte = frame_in[k];
            @(negedge clk);
            if (k == NB - 1) begin
                last_rx_cyc = cyc;
                rx_dv = 1'b0;
            end else begin
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    rx_dv = 1'b0;
                    repeat (gap) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_frame(input int fd_start, input string name);
        int n;
        n = 0;
        while (frame_done_cnt == fd_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (frame_done_cnt == fd_start) begin
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no frame_done in %0d cycles, want one", name, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_frame(input int fd_start, input string name);
        build_expected();
        compared++;
        if (tx_log.size() != NB) begin
            mismatched++;
            $display("[TB] FAIL %s_count: got %0d bytes, want %0d", name, tx_log.size(), NB);
        end
        for (int k = 0; k < NB && k < tx_log.size(); k++) begin
            compared++;
            if (tx_log[k] !== expected[k]) begin
                mismatched++;
                $display("[TB] FAIL %s_byte%0d: got %h, want %h", name, k, tx_log[k], expected[k]);
            end
        end
        compared++;
        if (frame_done_cnt - fd_start != 1) begin
            mismatched++;
            $display("[TB] FAIL %s_frame_done: got %0d pulses, want 1", name, frame_done_cnt - fd_start);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared += 5;
        if (tx_dv !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_tx_dv: got %b, want 0", tx_dv); end
        if (tx_byte !== 8'h00)   begin mismatched++; $display("[TB] FAIL reset_tx_byte: got %h, want 00", tx_byte); end
        if (busy !== 1'b0)       begin mismatched++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_done: got %b, want 0", frame_done); end
        if (rx_overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b, want 0", rx_overrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed_frame();
        logic [7:0] want [NB];
        int fd0;
`ifdef UART_SORT_DESCEND_EN
        want = '{8'hFF, 8'h80, 8'h7F, 8'h37, 8'h12, 8'h05, 8'h05, 8'h00};
`else
        want = '{8'h00, 8'h05, 8'h05, 8'h12, 8'h37, 8'h7F, 8'h80, 8'hFF};
`endif
        frame_in = '{8'h37, 8'h05, 8'hFF, 8'h00, 8'h80, 8'h05, 8'h12, 8'h7F};
        tx_len = 6;
        tx_log.delete();
        fd0 = frame_done_cnt;
        send_frame();
        wait_frame(fd0, "fixed");
        compared++;
        if (tx_log.size() != NB) begin
            mismatched++;
            $display("[TB] FAIL fixed_count: got %0d, want %0d", tx_log.size(), NB);
        end
        for (int k = 0; k < NB && k < tx_log.size(); k++) begin
            compared++;
            if (tx_log[k] !== want[k]) begin
                mismatched++;
                $display("[TB] FAIL fixed_byte%0d: got %h, want %h", k, tx_log[k], want[k]);
            end
        end
        compared++;
        if (frame_done_cnt - fd0 != 1) begin
            mismatched++;
            $display("[TB] FAIL fixed_frame_done: got %0d pulses, want 1", frame_done_cnt - fd0);
        end
    endtask

    task automatic test_latency();
        int fd0;
        for (int k = 0; k < NB; k++) frame_in[k] = 8'hAA;
        tx_len = $urandom_range(4, 8);
        tx_log.delete();
        tx_cyc.delete();
        fd0 = frame_done_cnt;
        send_frame();
        wait_frame(fd0, "latency");
        compared++;
        if (tx_cyc.size() == 0 || tx_cyc[0] - last_rx_cyc != 29) begin
            mismatched++;
            $display("[TB] FAIL latency_first_tx: got %0d cycles, want 29",
                     (tx_cyc.size() == 0) ? -1 : tx_cyc[0] - last_rx_cyc);
        end
        check_frame(fd0, "latency");
    endtask

    task automatic test_overrun();
        int fd0;
        int ov0;
        int n;
        random_frame(1'b0);
        tx_len = $urandom_range(4, 8);
        tx_log.delete();
        fd0 = frame_done_cnt;
        ov0 = overrun_cnt;
        send_frame();
        repeat (4) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overrun_busy_sort: got %b, want 1", busy);
        end
        rx_dv   = 1'b1;
        rx_byte = 8'h11;
        @(negedge clk);
        rx_dv = 1'b0;
        n = 0;
        while (tx_log.size() < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        rx_dv   = 1'b1;
        rx_byte = 8'h11;
        @(negedge clk);
        rx_dv = 1'b0;
        wait_frame(fd0, "overrun");
        compared++;
        if (overrun_cnt - ov0 != 2) begin
            mismatched++;
            $display("[TB] FAIL overrun_pulses: got %0d, want 2", overrun_cnt - ov0);
        end
        check_frame(fd0, "overrun");
    endtask

    task automatic test_tx_active_hold();
        int fd0;
        random_frame(1'b0);
        tx_len = $urandom_range(4, 8);
        tx_log.delete();
        tx_cyc.delete();
        fd0 = frame_done_cnt;
        send_frame();
        hold_active = 1'b1;
        repeat (78) @(negedge clk);
        compared += 2;
        if (tx_log.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL hold_early_tx: got %0d starts, want 0", tx_log.size());
        end
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hold_busy: got %b, want 1", busy);
        end
        hold_active = 1'b0;
        wait_frame(fd0, "hold");
        compared++;
        if (tx_cyc.size() == 0 || tx_cyc[0] - last_rx_cyc != 79) begin
            mismatched++;
            $display("[TB] FAIL hold_first_tx: got %0d cycles, want 79",
                     (tx_cyc.size() == 0) ? -1 : tx_cyc[0] - last_rx_cyc);
        end
        check_frame(fd0, "hold");
    endtask

    task automatic test_reset_mid_send();
        int fd0;
        int n;
        random_frame(1'b0);
        tx_len = $urandom_range(4, 8);
        tx_log.delete();
        fd0 = frame_done_cnt;
        send_frame();
        n = 0;
        while (tx_log.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (tx_dv !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_third_start: got tx_dv %b, want 1", tx_dv);
        end
        rst_n = 1'b0;
        #1;
        compared += 3;
        if (tx_dv !== 1'b0)    begin mismatched++; $display("[TB] FAIL midreset_tx_dv: got %b, want 0", tx_dv); end
        if (busy !== 1'b0)     begin mismatched++; $display("[TB] FAIL midreset_busy: got %b, want 0", busy); end
        if (tx_byte !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_tx_byte: got %h, want 00", tx_byte); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        compared += 2;
        if (tx_log.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL midreset_extra_tx: got %0d starts, want 3", tx_log.size());
        end
        if (frame_done_cnt != fd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_frame_done: got %0d pulses, want 0", frame_done_cnt - fd0);
        end
        random_frame(1'b1);
        tx_log.delete();
        fd0 = frame_done_cnt;
        send_frame();
        wait_frame(fd0, "after_reset");
        check_frame(fd0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int fd0;
        for (int r = 0; r < 4; r++) begin
            tx_log.delete();
            spurious_done = 1'b1;
            @(negedge clk);
            spurious_done = 1'b0;
            repeat (3) @(negedge clk);
            compared++;
            if (busy !== 1'b0 || tx_log.size() != 0) begin
                mismatched++;
                $display("[TB] FAIL spurious_done_r%0d: got busy %b starts %0d, want 0 and 0", r, busy, tx_log.size());
            end
            random_frame(r[0]);
            tx_len = $urandom_range(4, 8);
            fd0 = frame_done_cnt;
            send_frame();
            wait_frame(fd0, "b2b");
            check_frame(fd0, "b2b");
        end
    endtask

    // Test sequence.
    initial begin
        rst_n         = 1'b0;
        rx_dv         = 1'b0;
        rx_byte       = '0;
        hold_active   = 1'b0;
        spurious_done = 1'b0;
        test_reset();
        test_fixed_frame();
        test_latency();
        test_overrun();
        test_tx_active_hold();
        test_reset_mid_send();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_sort_ctrl.md
UART_SORT_CTRL -- requirements
Module: uart_sort_ctrl

Interface
REQ-001 Parameter NUM_BYTES, default 8, SHALL set the frame length in bytes (legal range 2..16).
REQ-002 Parameter DATA_W, default 8, SHALL set the byte width.
REQ-003 Port i_CLOCK, input, 1: the single clock; all logic SHALL sit on its rising edge.
REQ-004 Port i_RESET_N, input, 1: reset, SHALL be asynchronous and active-low.
REQ-005 Port i_Rx_DV, input, 1: one-cycle pulse marking a valid received byte.
REQ-006 Port i_Rx_Byte, input, DATA_W: the received byte, qualified by i_Rx_DV.
REQ-007 Port o_Tx_DV, output, 1: one-cycle pulse that starts transmission of o_Tx_Byte.
REQ-008 Port o_Tx_Byte, output, DATA_W: the byte to send, held stable from the o_Tx_DV cycle until i_Tx_Done.
REQ-009 Port i_Tx_Active, input, 1: the transmitter is busy.
REQ-010 Port i_Tx_Done, input, 1: one-cycle pulse marking the end of the stop bit.
REQ-011 Port o_Busy, output, 1: high in every state except COLLECT.
REQ-012 Port o_Frame_Done, output, 1: one-cycle pulse after the last sorted byte completes.
REQ-013 Port o_Rx_Overrun, output, 1: one-cycle pulse when an incoming byte is dropped.

Function
REQ-014 The FSM SHALL have four states: COLLECT, SORT, SEND, WAIT_DONE.
REQ-015 In COLLECT, each i_Rx_DV SHALL write i_Rx_Byte to buffer[wr_idx] and increment wr_idx.
REQ-016 The i_Rx_DV that writes index NUM_BYTES-1 SHALL reset wr_idx to 0 and move to SORT on the next cycle.
REQ-017 SORT SHALL be a bubble sort performing one compare, plus a swap if needed, per cycle, with outer pass i = 0..NUM_BYTES-2 and inner j = 0..NUM_BYTES-2-i.
REQ-018 SORT SHALL last exactly NUM_BYTES*(NUM_BYTES-1)/2 cycles (28 for NUM_BYTES=8) regardless of data, with no early exit.
REQ-019 Compares SHALL be unsigned over DATA_W bits; equal values SHALL NOT swap, so the sort is stable.
REQ-020 After the last compare, the FSM SHALL enter SEND with rd_idx=0.
REQ-021 First o_Tx_DV SHALL occur exactly 29 cycles after the cycle that sampled the final i_Rx_DV (NUM_BYTES=8).
REQ-022 SEND SHALL wait while i_Tx_Active is high, then pulse o_Tx_DV with o_Tx_Byte = buffer[rd_idx] and enter WAIT_DONE.
REQ-023 WAIT_DONE SHALL ignore i_Tx_Active and, on i_Tx_Done, increment rd_idx and return to SEND.
REQ-024 On the i_Tx_Done for rd_idx = NUM_BYTES-1, the FSM SHALL go to COLLECT and pulse o_Frame_Done in the same cycle.
REQ-025 An i_Rx_DV arriving outside COLLECT SHALL be discarded, pulse o_Rx_Overrun, and leave the buffer unmodified.
REQ-026 An i_Rx_DV in the same cycle as the COLLECT re-entry SHALL be discarded, with an overrun pulse.
REQ-027 A spurious i_Tx_Done outside WAIT_DONE SHALL be ignored.
REQ-028 o_Tx_DV SHALL never be asserted for two consecutive cycles.

Reset
REQ-029 Asserting i_RESET_N low SHALL immediately force COLLECT, wr_idx=0, rd_idx=0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Frame_Done=0 and o_Rx_Overrun=0.
REQ-030 Buffer contents SHALL NOT be reset.
REQ-031 Reset asserted mid-SORT or mid-SEND SHALL abandon the frame; after release, a complete new frame SHALL be required.

Configuration
REQ-032 With UART_SORT_DESCEND_EN defined, the swap condition SHALL be buffer[j] < buffer[j+1], giving descending output.
REQ-033 With UART_SORT_DESCEND_EN undefined, the swap condition SHALL be buffer[j] > buffer[j+1], giving ascending output.
REQ-034 Cycle counts SHALL be identical in both builds.

Structure
REQ-035 Package uart_sort_pkg SHALL hold the FSM state enum, the default NUM_BYTES/DATA_W constants, and a function returning the sort cycle count.
REQ-036 One sub-module, sort_cmp_swap, SHALL be used: a combinational compare/swap of two DATA_W operands carrying the UART_SORT_DESCEND_EN condition.
REQ-037 uart_sort_ctrl SHALL sit between the existing uart_rx and uart_tx in the top level, replacing the inline collection logic.

Verification
REQ-038 The bench SHALL cover: rx bytes 0x37,0x05,0xFF,0x00,0x80,0x05,0x12,0x7F -> tx sequence 0x00,0x05,0x05,0x12,0x37,0x7F,0x80,0xFF, with o_Frame_Done pulsed once.
REQ-039 The bench SHALL cover: the same frame with UART_SORT_DESCEND_EN defined -> 0xFF,0x80,0x7F,0x37,0x12,0x05,0x05,0x00.
REQ-040 The bench SHALL cover: 8 bytes of 0xAA -> first o_Tx_DV exactly 29 cycles after the 8th i_Rx_DV, and 8 transmissions of 0xAA.
REQ-041 The bench SHALL cover: i_Rx_DV of 0x11 injected during SORT and during WAIT_DONE -> two o_Rx_Overrun pulses and unchanged tx output.
REQ-042 The bench SHALL cover: i_RESET_N pulsed low after the 3rd tx byte -> o_Tx_DV=0 at once, no o_Frame_Done, and a new 8-byte frame sorted correctly.
REQ-043 The bench SHALL cover: i_Tx_Active held high for 50 cycles on SEND entry -> o_Tx_DV delayed until the cycle after i_Tx_Active falls.
